mc_control: RTL



---
 rtl/mc_control_if.sv | 40 ++++
 rtl/mc_control.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mc_control_if.sv
// Control/status bundle between the multicycle MIPS main controller and its datapath.
// The master side is the controller; the slave side is the datapath that consumes enables.
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic [2:0]       ALUOp;
    logic [5:0]       ALUFunc;
    logic             PCWrite;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic             illegal;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ALUOp, ALUFunc, PCWrite, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource,
               illegal, halted, instr_count
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ALUOp, ALUFunc, PCWrite, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource,
               illegal, halted, instr_count
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and ALU commands, and counts retired instructions.
module mc_control #(
    parameter bit ILLEGAL_HALT = 1'b0,
    parameter int CNT_W        = 32
) (
    input  logic           clk,
    input  logic           rst,
    mc_control_if.master   bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    // An instruction retires on the edge leaving its final state; illegal opcodes never retire.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_ADDI:      state_d = S_I_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
        count_d = retire ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Everything is forced low while rst is asserted so an abandoned instruction writes nothing.
    always_comb begin
        bus.ALUOp       = 3'b000;
        bus.ALUFunc     = 6'b000000;
        bus.PCWrite     = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.illegal     = illegal_q & ~rst;
        bus.halted      = (state_q == S_HALT) & ~rst;
        bus.instr_count = rst ? '0 : count_q;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.ALUOp   = 3'b001;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    bus.ALUOp   = 3'b001;
                end
                S_MEM_ADDR, S_I_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = 3'b001;
                end
                S_MEM_RD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                end
                S_MEM_WR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_R_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUFunc = bus.funct;
                end
                S_R_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                S_I_WB:   bus.RegWrite = 1'b1;
                S_BRANCH: begin
                    bus.ALUSrcA  = 1'b1;
                    bus.ALUOp    = 3'b010;
                    bus.PCSource = 2'b01;
                    bus.PCWrite  = bus.zero;
                end
                S_JUMP: begin
                    bus.PCSource = 2'b10;
                    bus.PCWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
